// File: rtl/spi_frontend_pkg.sv
// Shared constants for the SPI input front end: idle pad levels, default
// debounce wait, channel indices and counter widths.
package spi_frontend_pkg;

  localparam logic SCK_IDLE  = 1'b0;
  localparam logic CS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

  localparam int unsigned WAIT_DEFAULT = 3;

  // Debounce counter width; holds WAIT-1 for the full legal WAIT range 1..255.
  localparam int DB_CNT_W = 8;

  localparam int NUM_CH = 3;
  localparam int SCK    = 0;
  localparam int CS     = 1;
  localparam int MOSI   = 2;

  localparam logic [NUM_CH-1:0] IDLE_VEC = {MOSI_IDLE, CS_IDLE, SCK_IDLE};

endpackage

// File: rtl/input_conditioner_ch.sv
// One pad channel: 2-flop synchronizer, counter debouncer, registered
// rise/fall pulses gated by en_i, and a glitch flag.
// Glitch flag is only built when SPI_FRONTEND_GLITCH_CNT_EN is defined.
module input_conditioner_ch
  import spi_frontend_pkg::*;
#(
  parameter int unsigned WAIT = WAIT_DEFAULT,
  parameter logic        IDLE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic en_i,
  output logic cond_o,
  output logic rise_o,
  output logic fall_o,
  output logic glitch_o
);

  localparam logic [DB_CNT_W-1:0] CNT_MAX = DB_CNT_W'(WAIT - 1);

  logic                sync1_q, sync2_q;
  logic                cond_q, cond_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;
  logic                rise_q, rise_d, fall_q, fall_d;
  logic                diff, upd;

  // Debounce next state: count while the synced level disagrees, accept at WAIT.
  always_comb begin
    diff   = sync2_q ^ cond_q;
    upd    = diff && (cnt_q == CNT_MAX);
    cnt_d  = '0;
    cond_d = cond_q;
    if (diff && !upd) cnt_d = cnt_q + 1'b1;
    if (upd)          cond_d = sync2_q;
    rise_d = upd &  sync2_q & en_i;
    fall_d = upd & ~sync2_q & en_i;
  end

  // Synchronizer, debounce state and edge pulses; everything resets to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
      cond_q  <= IDLE;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cond_q  <= cond_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign cond_o = cond_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef SPI_FRONTEND_GLITCH_CNT_EN
  // A glitch: the input fell back to the accepted level before WAIT elapsed.
  assign glitch_o = (sync2_q == cond_q) && (cnt_q != '0);
`else
  assign glitch_o = 1'b0;
`endif

endmodule

// File: rtl/spi_input_frontend.sv
// SPI pad conditioner: three conditioned channels, SCK edges qualified by the
// conditioned chip select, frame pulses, and a saturating glitch counter.
// Optional: SPI_FRONTEND_GLITCH_CNT_EN builds the glitch counter; otherwise
// glitch_cnt is tied to 0.
module spi_input_frontend
  import spi_frontend_pkg::*;
#(
  parameter int unsigned WAIT     = WAIT_DEFAULT,
  parameter int          GLITCH_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sck_raw,
  input  logic                cs_raw,
  input  logic                mosi_raw,
  output logic                sck_c,
  output logic                cs_c,
  output logic                mosi_c,
  output logic                sck_rise,
  output logic                sck_fall,
  output logic                frame_start,
  output logic                frame_end,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  logic [NUM_CH-1:0] raw, en, cond, rise, fall, glitch;

  assign raw = {mosi_raw, cs_raw, sck_raw};
  // SCK edges count only when the frame was open before this update.
  assign en  = {1'b1, 1'b1, ~cond[CS]};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    input_conditioner_ch #(
      .WAIT (WAIT),
      .IDLE (IDLE_VEC[c])
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (raw[c]),
      .en_i     (en[c]),
      .cond_o   (cond[c]),
      .rise_o   (rise[c]),
      .fall_o   (fall[c]),
      .glitch_o (glitch[c])
    );
  end

  assign sck_c       = cond[SCK];
  assign cs_c        = cond[CS];
  assign mosi_c      = cond[MOSI];
  assign sck_rise    = rise[SCK];
  assign sck_fall    = fall[SCK];
  assign frame_start = fall[CS];
  assign frame_end   = rise[CS];

  // MOSI is sampled by the core on sck_rise, so its own edges go nowhere.
  logic unused_mosi_edges;
  assign unused_mosi_edges = rise[MOSI] ^ fall[MOSI];

`ifdef SPI_FRONTEND_GLITCH_CNT_EN
  localparam int GW1 = GLITCH_W + 1;

  logic [GLITCH_W-1:0] glitch_cnt_q, glitch_cnt_d;
  logic [GLITCH_W:0]   gsum;

  // Sum simultaneous glitches with one spare bit; saturate on carry-out.
  always_comb begin
    gsum = {1'b0, glitch_cnt_q} + GW1'(glitch[SCK]) + GW1'(glitch[CS])
         + GW1'(glitch[MOSI]);
    glitch_cnt_d = gsum[GLITCH_W] ? '1 : gsum[GLITCH_W-1:0];
  end

  // Glitch accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) glitch_cnt_q <= '0;
    else        glitch_cnt_q <= glitch_cnt_d;
  end

  assign glitch_cnt = glitch_cnt_q;
`else
  logic unused_glitch;
  assign unused_glitch = ^glitch;
  assign glitch_cnt    = '0;
`endif

endmodule
